// File: rtl/orion_clk_demux.sv
// rtl/orion_clk_demux.sv - clocked two-phase bundled-data demultiplexer (one token in flight)
// Define ORION_CLK_DEMUX_ERR_EN to add the sticky protocol-error output err.
module orion_clk_demux #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  output logic             in_ack,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             outA_req,
  input  logic             outA_ack,
  output logic             outB_req,
  input  logic             outB_ack,
  output logic [WIDTH-1:0] outA_data,
  output logic [WIDTH-1:0] outB_data
`ifdef ORION_CLK_DEMUX_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] req_sync, ackA_sync, ackB_sync;
  logic                   req_s, ackA_s, ackB_s;
  logic                   sel_q, sel_n;
  logic [WIDTH-1:0]       data_q, data_n;
  logic                   in_ack_n, outA_req_n, outB_req_n;
  logic                   pending, sel_done;

  // Each two-phase input crosses into clk through its own flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync  <= '0;
      ackA_sync <= '0;
      ackB_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], in_req};
      ackA_sync <= {ackA_sync[SYNC_STAGES-2:0], outA_ack};
      ackB_sync <= {ackB_sync[SYNC_STAGES-2:0], outB_ack};
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign ackA_s = ackA_sync[SYNC_STAGES-1];
  assign ackB_s = ackB_sync[SYNC_STAGES-1];

  assign pending  = (req_s != in_ack);
  assign sel_done = sel_q ? (ackB_s == outB_req) : (ackA_s == outA_req);

  always_comb begin
    state_n    = state;
    sel_n      = sel_q;
    data_n     = data_q;
    in_ack_n   = in_ack;
    outA_req_n = outA_req;
    outB_req_n = outB_req;
    case (state)
      IDLE: begin
        if (pending) begin
          data_n   = in_data;
          sel_n    = in_sel;
          in_ack_n = ~in_ack;
          if (in_sel) outB_req_n = ~outB_req;
          else        outA_req_n = ~outA_req;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        // The unselected channel's ack never releases the FSM.
        if (sel_done) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      data_q   <= '0;
      in_ack   <= 1'b0;
      outA_req <= 1'b0;
      outB_req <= 1'b0;
    end else begin
      state    <= state_n;
      sel_q    <= sel_n;
      data_q   <= data_n;
      in_ack   <= in_ack_n;
      outA_req <= outA_req_n;
      outB_req <= outB_req_n;
    end
  end

  assign outA_data = data_q;
  assign outB_data = data_q;

`ifdef ORION_CLK_DEMUX_ERR_EN
  logic req_d, ackA_d, ackB_d, err_q;

  // Delayed copies expose each synchronized transition one edge after it lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_d  <= 1'b0;
      ackA_d <= 1'b0;
      ackB_d <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      req_d  <= req_s;
      ackA_d <= ackA_s;
      ackB_d <= ackB_s;
      if (((ackA_s != ackA_d) && (ackA_d == outA_req)) ||
          ((ackB_s != ackB_d) && (ackB_d == outB_req)) ||
          ((state == BUSY) && (req_s != req_d) && (req_d != in_ack)))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
